// File: rtl/lsu_pkg.sv
// Shared types and encodings for the load/store unit: FSM states, access sizes,
// RV32I funct3 codes and response fault codes.
package lsu_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ACC1 = 2'd1,
        ST_ACC2 = 2'd2,
        ST_RESP = 2'd3
    } lsu_state_e;

    localparam logic [1:0] SEC_BYTE = 2'b00;
    localparam logic [1:0] SEC_HALF = 2'b01;
    localparam logic [1:0] SEC_WORD = 2'b10;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    localparam logic [1:0] FLT_OK  = 2'b00;
    localparam logic [1:0] FLT_MIS = 2'b01;
    localparam logic [1:0] FLT_OOR = 2'b10;
    localparam logic [1:0] FLT_ILL = 2'b11;

    // Registered view of an accepted request; only the fields needed after acceptance.
    typedef struct packed {
        logic       is_load;
        logic [2:0] f3;
        logic [1:0] off;
        logic       mis;
    } lsu_req_t;

    // Unsigned variants exist only for loads.
    function automatic logic f3_legal(input logic is_load, input logic [2:0] f3);
        case (f3)
            F3_B, F3_H, F3_W: f3_legal = 1'b1;
            F3_BU, F3_HU:     f3_legal = is_load;
            default:          f3_legal = 1'b0;
        endcase
    endfunction

    function automatic logic [2:0] f3_bytes(input logic [2:0] f3);
        case (f3[1:0])
            2'b00:   f3_bytes = 3'd1;
            2'b01:   f3_bytes = 3'd2;
            default: f3_bytes = 3'd4;
        endcase
    endfunction

endpackage

// File: rtl/load_store_unit_if.sv
// Core-side request/response bus and memory-side access bus of the load/store unit.
interface lsu_core_if;
    logic        req_valid_i;
    logic        req_ready_o;
    logic        is_load_i;
    logic [2:0]  funct3_i;
    logic [31:0] addr_i;
    logic [31:0] wdata_i;
    logic        resp_valid_o;
    logic [31:0] rdata_o;
    logic [1:0]  fault_o;

    modport master (
        output req_valid_i, is_load_i, funct3_i, addr_i, wdata_i,
        input  req_ready_o, resp_valid_o, rdata_o, fault_o
    );
    modport slave (
        input  req_valid_i, is_load_i, funct3_i, addr_i, wdata_i,
        output req_ready_o, resp_valid_o, rdata_o, fault_o
    );
endinterface

interface lsu_mem_if;
    logic        mem_req_o;
    logic        memRW_o;
    logic [1:0]  dataSec_o;
    logic [31:0] addr_o;
    logic [31:0] dataW_o;
    logic        mem_ack_i;
    logic [31:0] data_i;

    modport master (
        output mem_req_o, memRW_o, dataSec_o, addr_o, dataW_o,
        input  mem_ack_i, data_i
    );
    modport slave (
        input  mem_req_o, memRW_o, dataSec_o, addr_o, dataW_o,
        output mem_ack_i, data_i
    );
endinterface

// File: rtl/load_align.sv
// Extracts the addressed byte/half/word from a 32-bit read word and extends it.
module load_align
    import lsu_pkg::*;
(
    input  logic [31:0] data,
    input  logic [1:0]  offset,
    input  logic [2:0]  funct3,
    output logic [31:0] result
);

    logic [31:0] sh;
    assign sh = data >> {offset, 3'b000};

    always_comb begin
        case (funct3)
            F3_B:    result = {{24{sh[7]}}, sh[7:0]};
            F3_H:    result = {{16{sh[15]}}, sh[15:0]};
            F3_BU:   result = {24'b0, sh[7:0]};
            F3_HU:   result = {16'b0, sh[15:0]};
            default: result = sh;
        endcase
    end

endmodule

// File: rtl/load_store_unit.sv
// RV32I load/store unit: accepts one request at a time, issues one or two memory
// accesses (misaligned loads are split into two word reads) and returns a response.
module load_store_unit
    import lsu_pkg::*;
#(
    parameter int ADDR_BITS = 11
) (
    input logic       clk,
    input logic       rst,
    lsu_core_if.slave core,
    lsu_mem_if.master mem
);

    lsu_state_e  st, st_n;
    lsu_req_t    rq, rq_n;
    logic [31:0] word0, word0_n;
    logic        mreq, mreq_n, mrw, mrw_n;
    logic [1:0]  msec, msec_n;
    logic [31:0] maddr, maddr_n, mdw, mdw_n;
    logic        rvld, rvld_n;
    logic [31:0] rdat, rdat_n;
    logic [1:0]  flt, flt_n;
    logic        done;

    // Acceptance-time decode
    logic [2:0]  nbytes;
    logic        mis_in, oor, mis_ld;
    logic [32:0] lim, last_b, word2;
    logic [31:0] wmask;
    logic [1:0]  flt_in;

    assign lim    = 33'd1 << ADDR_BITS;
    assign nbytes = f3_bytes(core.funct3_i);
    assign mis_in = (nbytes == 3'd2 && core.addr_i[0]) ||
                    (nbytes == 3'd4 && core.addr_i[1:0] != 2'b00);
    assign mis_ld = core.is_load_i && mis_in;
    assign last_b = {1'b0, core.addr_i} + 33'(nbytes) - 33'd1;
    assign word2  = {1'b0, core.addr_i[31:2], 2'b00} + 33'd4;
    // A split load touches the whole second word, so that word must be in range too.
    assign oor    = (last_b >= lim) || (mis_ld && word2 >= lim);

    always_comb begin
        case (nbytes)
            3'd1:    wmask = {24'b0, core.wdata_i[7:0]};
            3'd2:    wmask = {16'b0, core.wdata_i[15:0]};
            default: wmask = core.wdata_i;
        endcase
    end

    always_comb begin
        if (!f3_legal(core.is_load_i, core.funct3_i)) flt_in = FLT_ILL;
        else if (oor)                                 flt_in = FLT_OOR;
        else if (!core.is_load_i && mis_in)           flt_in = FLT_MIS;
        else                                          flt_in = FLT_OK;
    end

    // Split loads: the low word is held in word0, the pair shifted down by the offset.
    logic [31:0] merged, a_data, a_res;
    logic [1:0]  a_off;
    assign merged = 32'({mem.data_i, word0} >> {rq.off, 3'b000});
    assign a_data = rq.mis ? merged : mem.data_i;
    assign a_off  = rq.mis ? 2'b00 : rq.off;

    load_align u_align (
        .data   (a_data),
        .offset (a_off),
        .funct3 (rq.f3),
        .result (a_res)
    );

    always_comb begin
        st_n    = st;
        rq_n    = rq;
        word0_n = word0;
        mreq_n  = mreq;
        mrw_n   = mrw;
        msec_n  = msec;
        maddr_n = maddr;
        mdw_n   = mdw;
        rvld_n  = 1'b0;
        rdat_n  = rdat;
        flt_n   = flt;
        done    = 1'b0;
        case (st)
            ST_IDLE: begin
                if (core.req_valid_i) begin
                    rq_n = '{is_load: core.is_load_i, f3: core.funct3_i,
                             off: core.addr_i[1:0], mis: mis_ld};
                    if (flt_in != FLT_OK) begin
                        st_n   = ST_RESP;
                        rvld_n = 1'b1;
                        flt_n  = flt_in;
                        rdat_n = '0;
                    end else begin
                        st_n   = ST_ACC1;
                        mreq_n = 1'b1;
                        mrw_n  = core.is_load_i;
                        if (mis_ld) begin
                            msec_n  = SEC_WORD;
                            maddr_n = {core.addr_i[31:2], 2'b00};
                            mdw_n   = '0;
                        end else begin
                            msec_n  = core.funct3_i[1:0];
                            maddr_n = core.addr_i;
                            mdw_n   = core.is_load_i ? 32'd0 : wmask;
                        end
                    end
                end
            end
            ST_ACC1: begin
                if (mem.mem_ack_i) begin
                    if (rq.mis) begin
                        st_n    = ST_ACC2;
                        word0_n = mem.data_i;
                        maddr_n = maddr + 32'd4;
                    end else begin
                        done = 1'b1;
                    end
                end
            end
            ST_ACC2: if (mem.mem_ack_i) done = 1'b1;
            default: st_n = ST_IDLE;
        endcase
        if (done) begin
            st_n    = ST_RESP;
            rvld_n  = 1'b1;
            flt_n   = FLT_OK;
            rdat_n  = rq.is_load ? a_res : 32'd0;
            mreq_n  = 1'b0;
            mrw_n   = 1'b1;
            msec_n  = SEC_BYTE;
            maddr_n = '0;
            mdw_n   = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            st    <= ST_IDLE;
            rq    <= '0;
            word0 <= '0;
            mreq  <= 1'b0;
            mrw   <= 1'b1;
            msec  <= SEC_BYTE;
            maddr <= '0;
            mdw   <= '0;
            rvld  <= 1'b0;
            rdat  <= '0;
            flt   <= FLT_OK;
        end else begin
            st    <= st_n;
            rq    <= rq_n;
            word0 <= word0_n;
            mreq  <= mreq_n;
            mrw   <= mrw_n;
            msec  <= msec_n;
            maddr <= maddr_n;
            mdw   <= mdw_n;
            rvld  <= rvld_n;
            rdat  <= rdat_n;
            flt   <= flt_n;
        end
    end

    assign core.req_ready_o  = (st == ST_IDLE);
    assign core.resp_valid_o = rvld;
    assign core.rdata_o      = rdat;
    assign core.fault_o      = flt;
    assign mem.mem_req_o     = mreq;
    assign mem.memRW_o       = mrw;
    assign mem.dataSec_o     = msec;
    assign mem.addr_o        = maddr;
    assign mem.dataW_o       = mdw;

endmodule

// File: tb/tb_load_store_unit.sv
// Randomized and directed bench for load_store_unit against a byte-level memory model.
module tb_load_store_unit;
    import lsu_pkg::*;

    localparam int AB  = 11;
    localparam int MSZ = 1 << AB;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    lsu_core_if core ();
    lsu_mem_if  mem ();

    load_store_unit #(.ADDR_BITS(AB)) dut (
        .clk  (clk),
        .rst  (rst),
        .core (core),
        .mem  (mem)
    );

    int n_tests = 0;
    int n_fail  = 0;
    logic [7:0] mem_arr [MSZ];
    logic [7:0] ref_mem [MSZ];
    int   ack_delay = 0;
    logic late_ack  = 1'b0;
    logic [31:0] last_rd;
    logic [1:0]  last_flt;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic set_word(input int a, input logic [31:0] w);
        for (int i = 0; i < 4; i++) begin
            mem_arr[a+i] = w[8*i +: 8];
            ref_mem[a+i] = w[8*i +: 8];
        end
    endtask

    // Memory: acks after ack_delay wait cycles, returns the aligned word, commits stores.
    initial begin : responder
        int wcnt;
        int b;
        int nb;
        wcnt = 0;
        mem.mem_ack_i = 1'b0;
        mem.data_i    = '0;
        forever begin
            @(negedge clk);
            mem.mem_ack_i = late_ack;
            if (mem.mem_req_o) begin
                if (wcnt >= ack_delay) begin
                    b = int'(mem.addr_o & 32'(MSZ - 4));
                    mem.data_i = {mem_arr[b+3], mem_arr[b+2], mem_arr[b+1], mem_arr[b]};
                    if (!mem.memRW_o) begin
                        nb = (mem.dataSec_o == 2'b00) ? 1 : (mem.dataSec_o == 2'b01) ? 2 : 4;
                        b  = int'(mem.addr_o & 32'(MSZ - 1));
                        for (int i = 0; i < nb; i++) mem_arr[(b+i) % MSZ] = mem.dataW_o[8*i +: 8];
                    end
                    mem.mem_ack_i = 1'b1;
                    wcnt = 0;
                end else begin
                    wcnt++;
                end
            end else begin
                wcnt = 0;
            end
        end
    end

    // Reference: byte-addressed semantics of an RV32I load/store.
    task automatic model(input logic ld, input logic [2:0] f3, input logic [31:0] addr,
                         input logic [31:0] wd, output logic [1:0] eflt, output logic [31:0] erd,
                         output int nacc, output logic [1:0] esec, output logic [31:0] eaddr,
                         output logic [31:0] edw);
        int nb;
        logic legal, mis, sgn;
        longint last, v;
        legal = ld ? (f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5}) : (f3 inside {3'd0, 3'd1, 3'd2});
        sgn   = (f3 == 3'd0) || (f3 == 3'd1);
        case (f3)
            3'd0, 3'd4: nb = 1;
            3'd1, 3'd5: nb = 2;
            default:    nb = 4;
        endcase
        mis  = (addr % nb) != 0;
        last = longint'(addr) + nb - 1;
        if (ld && mis) last = longint'(addr / 4) * 4 + 7;
        if (!legal)               eflt = FLT_ILL;
        else if (last >= MSZ)     eflt = FLT_OOR;
        else if (!ld && mis)      eflt = FLT_MIS;
        else                      eflt = FLT_OK;
        nacc  = (eflt != FLT_OK) ? 0 : (ld && mis) ? 2 : 1;
        esec  = (ld && mis) ? 2'b10 : (nb == 1) ? 2'b00 : (nb == 2) ? 2'b01 : 2'b10;
        eaddr = (ld && mis) ? (addr / 4) * 4 : addr;
        edw   = ld ? 32'd0 : 32'(longint'(wd) & ((longint'(1) << (8*nb)) - 1));
        erd   = '0;
        if (eflt == FLT_OK && ld) begin
            v = 0;
            for (int i = 0; i < nb; i++) v = v | (longint'(ref_mem[int'(addr)+i]) << (8*i));
            if (sgn && v[8*nb-1]) v = v - (longint'(1) << (8*nb));
            erd = v[31:0];
        end
        if (eflt == FLT_OK && !ld)
            for (int i = 0; i < nb; i++) ref_mem[int'(addr)+i] = wd[8*i +: 8];
    endtask

    task automatic run(input logic ld, input logic [2:0] f3, input logic [31:0] addr,
                       input logic [31:0] wd, input string tag);
        logic [1:0]  eflt, esec, gflt;
        logic [31:0] erd, eaddr, edw, grd, a1, a2;
        int nacc, cyc, nreq;
        logic seen, rdy_hi, first;
        model(ld, f3, addr, wd, eflt, erd, nacc, esec, eaddr, edw);
        @(negedge clk);
        chk({tag, "/rdy_idle"}, 32'(core.req_ready_o), 32'd1);
        core.req_valid_i = 1'b1;
        core.is_load_i   = ld;
        core.funct3_i    = f3;
        core.addr_i      = addr;
        core.wdata_i     = wd;
        @(posedge clk);
        seen = 0; rdy_hi = 0; first = 1; cyc = 0; nreq = 0;
        grd = '0; gflt = '0; a1 = '0; a2 = '0;
        while (!seen && cyc < 100) begin
            @(negedge clk);
            cyc++;
            core.req_valid_i = 1'b0;
            if (core.req_ready_o) rdy_hi = 1;
            if (mem.mem_req_o) begin
                nreq++;
                if (first) begin
                    first = 0;
                    a1 = mem.addr_o;
                    chk({tag, "/memRW"},   32'(mem.memRW_o),   32'(ld));
                    chk({tag, "/dataSec"}, 32'(mem.dataSec_o), 32'(esec));
                    chk({tag, "/addr_o"},  mem.addr_o,         eaddr);
                    chk({tag, "/dataW"},   mem.dataW_o,        edw);
                end else if (mem.addr_o != a1) begin
                    a2 = mem.addr_o;
                end
            end
            if (core.resp_valid_o) begin
                seen = 1;
                grd  = core.rdata_o;
                gflt = core.fault_o;
            end
        end
        chk({tag, "/resp_seen"}, 32'(seen), 32'd1);
        chk({tag, "/fault"}, 32'(gflt), 32'(eflt));
        chk({tag, "/rdata"}, grd, erd);
        if (ack_delay == 0)
            chk({tag, "/latency"}, 32'(cyc), (eflt != FLT_OK) ? 32'd1 : (nacc == 2) ? 32'd3 : 32'd2);
        chk({tag, "/mem_req_cycles"}, 32'(nreq), 32'(nacc * (ack_delay + 1)));
        if (nacc == 2) chk({tag, "/addr2"}, a2, eaddr + 32'd4);
        chk({tag, "/rdy_low"}, 32'(rdy_hi), 32'd0);
        @(negedge clk);
        chk({tag, "/resp_pulse"}, 32'(core.resp_valid_o), 32'd0);
        chk({tag, "/rdy_back"}, 32'(core.req_ready_o), 32'd1);
        chk({tag, "/rdata_hold"}, core.rdata_o, grd);
        last_rd  = grd;
        last_flt = gflt;
    endtask

    initial begin : main
        logic [7:0] b;
        int r;
        logic [31:0] ad;
        core.req_valid_i = 1'b0;
        core.is_load_i   = 1'b0;
        core.funct3_i    = '0;
        core.addr_i      = '0;
        core.wdata_i     = '0;
        for (int i = 0; i < MSZ; i++) begin
            b = 8'($urandom);
            mem_arr[i] = b;
            ref_mem[i] = b;
        end
        repeat (3) @(negedge clk);
        rst = 1'b0;
        chk("rst/ready",   32'(core.req_ready_o),  32'd1);
        chk("rst/resp",    32'(core.resp_valid_o), 32'd0);
        chk("rst/rdata",   core.rdata_o,           32'd0);
        chk("rst/fault",   32'(core.fault_o),      32'd0);
        chk("rst/mem_req", 32'(mem.mem_req_o),     32'd0);
        chk("rst/memRW",   32'(mem.memRW_o),       32'd1);
        chk("rst/dataSec", 32'(mem.dataSec_o),     32'd0);
        chk("rst/addr_o",  mem.addr_o,             32'd0);
        chk("rst/dataW",   mem.dataW_o,            32'd0);

        ack_delay = 0;
        run(1'b0, F3_W, 32'h0, 32'hAAAAAAAA, "sw0");
        chk("sw0/fault_c", 32'(last_flt), 32'd0);
        set_word(0, 32'h80FF1234);
        run(1'b1, F3_B, 32'h3, 32'h0, "lb3");
        chk("lb3/const", last_rd, 32'hFFFFFF80);
        run(1'b1, F3_BU, 32'h3, 32'h0, "lbu3");
        chk("lbu3/const", last_rd, 32'h00000080);
        set_word(4, 32'hBBBB1111);
        ack_delay = 3;
        run(1'b1, F3_H, 32'h6, 32'h0, "lh6");
        chk("lh6/const", last_rd, 32'hFFFFBBBB);
        ack_delay = 0;
        set_word(0, 32'h44332211);
        set_word(4, 32'h88776655);
        run(1'b1, F3_W, 32'h2, 32'h0, "lw2");
        chk("lw2/const", last_rd, 32'h66554433);
        run(1'b0, F3_W, 32'h11, 32'h12345678, "swmis");
        chk("swmis/const", 32'(last_flt), 32'(FLT_MIS));
        run(1'b1, F3_W, 32'h800, 32'h0, "lwoor");
        chk("lwoor/const", 32'(last_flt), 32'(FLT_OOR));
        run(1'b1, 3'b011, 32'h0, 32'h0, "ill");
        chk("ill/const", 32'(last_flt), 32'(FLT_ILL));

        // Reset while the first access waits for its ack.
        ack_delay = 20;
        @(negedge clk);
        core.req_valid_i = 1'b1;
        core.is_load_i   = 1'b1;
        core.funct3_i    = F3_W;
        core.addr_i      = 32'h10;
        @(posedge clk);
        @(negedge clk);
        core.req_valid_i = 1'b0;
        chk("rstacc/mem_req", 32'(mem.mem_req_o), 32'd1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("rstacc/ready",   32'(core.req_ready_o),  32'd1);
        chk("rstacc/resp",    32'(core.resp_valid_o), 32'd0);
        chk("rstacc/mem_req0", 32'(mem.mem_req_o),    32'd0);
        chk("rstacc/memRW",   32'(mem.memRW_o),       32'd1);
        late_ack = 1'b1;
        repeat (2) begin
            @(negedge clk);
            chk("rstacc/late_resp",  32'(core.resp_valid_o), 32'd0);
            chk("rstacc/late_ready", 32'(core.req_ready_o),  32'd1);
        end
        late_ack = 1'b0;
        @(negedge clk);
        ack_delay = 0;

        for (int n = 0; n < 250; n++) begin
            r = $urandom_range(0, 9);
            if (r < 7)      ad = 32'($urandom_range(0, MSZ - 1));
            else if (r < 9) ad = 32'(MSZ - 8 + $urandom_range(0, 7));
            else            ad = $urandom;
            ack_delay = $urandom_range(0, 3);
            run(1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), ad, $urandom, "rnd");
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
